// File: rtl/load_store_unit_pkg.sv
// Shared load/store types and decode helpers for the memory stage.
package instruction_utils;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        ALU = 4'd1,
        LB  = 4'd2,
        LH  = 4'd3,
        LW  = 4'd4,
        LBU = 4'd5,
        LHU = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9
    } rv32i_instr_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } lsu_size_e;

    function automatic logic is_load(rv32i_instr_e op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic is_store(rv32i_instr_e op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic lsu_size_e lsu_size(rv32i_instr_e op);
        case (op)
            LB, LBU, SB: return BYTE;
            LH, LHU, SH: return HALF;
            default:     return WORD;
        endcase
    endfunction

    function automatic logic lsu_is_unsigned(rv32i_instr_e op);
        return op inside {LBU, LHU};
    endfunction

    function automatic logic is_misaligned(rv32i_instr_e op, logic [1:0] off);
        if (!(is_load(op) || is_store(op))) return 1'b0;
        case (lsu_size(op))
            HALF:    return off[0];
            WORD:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: load extraction/extension and store replication/strobes.
module lsu_align
    import instruction_utils::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  lsu_size_e   size_i,
    input  logic        uns_i,
    input  logic [31:0] sd_i,
    output logic [31:0] load_data_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata_i[{off_i, 3'b000} +: 8];
    assign half_v = rdata_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        load_data_o = rdata_i;
        wdata_o     = sd_i;
        wstrb_o     = 4'b1111;
        unique case (size_i)
            BYTE: begin
                load_data_o = {{24{~uns_i & byte_v[7]}}, byte_v};
                wdata_o     = {4{sd_i[7:0]}};
                wstrb_o     = 4'b0001 << off_i;
            end
            HALF: begin
                load_data_o = {{16{~uns_i & half_v[15]}}, half_v};
                wdata_o     = {2{sd_i[15:0]}};
                wstrb_o     = 4'b0011 << off_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one word-wide data-memory transaction per accepted load/store,
// with misalignment trap, response watchdog and extended load result.
module load_store_unit
    import instruction_utils::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  rv32i_instr_e instr,
    input  logic [31:0]  addr,
    input  logic [31:0]  store_data,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  mem_addr,
    output logic         mem_we,
    output logic [3:0]   mem_wstrb,
    output logic [31:0]  mem_wdata,
    input  logic         mem_rsp_valid,
    input  logic [31:0]  mem_rdata,
    output logic         done,
    output logic [31:0]  load_data,
    output logic         misaligned,
    output logic         bus_error
);

    lsu_state_e   state_q, state_d;
    rv32i_instr_e instr_q, instr_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  sd_q, sd_d;
    logic [31:0]  ld_q, ld_d;
    logic         mis_q, mis_d;
    logic         err_q, err_d;
    logic [31:0]  wdog_q, wdog_d;

    logic [31:0]  al_ld;
    logic [31:0]  al_wdata;
    logic [3:0]   al_wstrb;
    lsu_size_e    size_q;
    logic         uns_q;

    assign size_q = lsu_size(instr_q);
    assign uns_q  = lsu_is_unsigned(instr_q);

    lsu_align u_align (
        .rdata_i     (mem_rdata),
        .off_i       (addr_q[1:0]),
        .size_i      (size_q),
        .uns_i       (uns_q),
        .sd_i        (sd_q),
        .load_data_o (al_ld),
        .wdata_o     (al_wdata),
        .wstrb_o     (al_wstrb)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        sd_d    = sd_q;
        ld_d    = ld_q;
        mis_d   = mis_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    instr_d = instr;
                    addr_d  = addr;
                    sd_d    = store_data;
                    ld_d    = '0;
                    mis_d   = 1'b0;
                    err_d   = 1'b0;
                    if (!(is_load(instr) || is_store(instr))) begin
                        state_d = DONE;
                    end else if (is_misaligned(instr, addr[1:0])) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT_RSP;
                    wdog_d  = '0;
                end
            end
            WAIT_RSP: begin
                // Counter reads 1 on the first waiting cycle; response beats expiry.
                wdog_d = wdog_q + 32'd1;
                if (mem_rsp_valid) begin
                    state_d = DONE;
                    ld_d    = is_load(instr_q) ? al_ld : '0;
                end else if (TIMEOUT_CYCLES != 0 && wdog_d == TIMEOUT_CYCLES) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            instr_q <= NOP;
            addr_q  <= '0;
            sd_q    <= '0;
            ld_q    <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            sd_q    <= sd_d;
            ld_q    <= ld_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    assign in_ready      = state_q == IDLE;
    assign mem_req_valid = state_q == REQ;
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_we        = mem_req_valid && is_store(instr_q);
    assign mem_wstrb     = mem_we ? al_wstrb : 4'b0000;
    assign mem_wdata     = al_wdata;
    assign done          = state_q == DONE;
    assign misaligned    = done && mis_q;
    assign bus_error     = done && err_q;
    assign load_data     = ld_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a lane-arithmetic reference model.
module tb_load_store_unit;
    import instruction_utils::*;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    rv32i_instr_e instr = NOP;
    logic [31:0]  addr = '0;
    logic [31:0]  store_data = '0;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_addr;
    logic         mem_we;
    logic [3:0]   mem_wstrb;
    logic [31:0]  mem_wdata;
    logic         mem_rsp_valid = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         done;
    logic [31:0]  load_data;
    logic         misaligned;
    logic         bus_error;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .addr          (addr),
        .store_data    (store_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .done          (done),
        .load_data     (load_data),
        .misaligned    (misaligned),
        .bus_error     (bus_error)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          rdy;
        int          rsp;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        logic        mis;
        logic        err;
        logic [31:0] ld;
    } cpl_t;

    req_t req_q[$];
    cpl_t cpl_q[$];

    int checks = 0;
    int failures = 0;
    int stray_cnt = 0;
    logic [31:0] last_ld = '0;

    rv32i_instr_e ops [10] = '{NOP, ALU, LB, LH, LW, LBU, LHU, SB, SH, SW};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic bit m_load(rv32i_instr_e op);
        return op == LB || op == LH || op == LW || op == LBU || op == LHU;
    endfunction

    function automatic bit m_store(rv32i_instr_e op);
        return op == SB || op == SH || op == SW;
    endfunction

    function automatic bit m_misal(rv32i_instr_e op, int off);
        if (op == LH || op == LHU || op == SH) return (off % 2) != 0;
        if (op == LW || op == SW) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_ld(rv32i_instr_e op, int off, logic [31:0] rd);
        int unsigned b;
        int unsigned h;
        b = (rd >> (8 * off)) & 255;
        h = (rd >> (16 * (off / 2))) & 65535;
        case (op)
            LB:      return (b >= 128) ? b - 256 : b;
            LH:      return (h >= 32768) ? h - 65536 : h;
            LBU:     return b;
            LHU:     return h;
            LW:      return rd;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(rv32i_instr_e op, int off);
        case (op)
            SB:      return 4'(1 << off);
            SH:      return 4'(3 << off);
            SW:      return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(rv32i_instr_e op, logic [31:0] sd);
        case (op)
            SB:      return (sd & 32'hFF) * 32'h0101_0101;
            SH:      return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    task automatic chk_req(input req_t r, input string tag);
        chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, r.addr);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(r.we));
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(r.wstrb));
        if (r.we) chk({tag, "_mem_wdata"}, mem_wdata, r.wdata);
    endtask

    // Memory responder and request checker
    initial begin
        req_t r;
        int stray_done;
        stray_done = 0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'(req_q.size()), 32'd1);
                end else begin
                    r = req_q.pop_front();
                    for (int i = 0; i < r.rdy; i++) begin
                        chk_req(r, "stall");
                        @(negedge clk);
                    end
                    chk_req(r, "hs");
                    mem_req_ready = 1'b1;
                    @(negedge clk);
                    mem_req_ready = 1'b0;
                    if (r.rsp > 0) begin
                        repeat (r.rsp - 1) @(negedge clk);
                        mem_rsp_valid = 1'b1;
                        mem_rdata = r.rdata;
                        @(negedge clk);
                        mem_rsp_valid = 1'b0;
                        mem_rdata = $urandom;
                    end
                end
            end else if (stray_cnt != stray_done) begin
                stray_done = stray_cnt;
                mem_rsp_valid = 1'b1;
                mem_rdata = $urandom;
                @(negedge clk);
                mem_rsp_valid = 1'b0;
            end
        end
    end

    // Completion monitor
    initial begin
        cpl_t c;
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_ld = '0;
                prev = 1'b0;
            end else begin
                if (done) begin
                    chk("done_one_cycle", 32'(prev), 32'd0);
                    if (cpl_q.size() == 0) begin
                        chk("unexpected_done", 32'(cpl_q.size()), 32'd1);
                    end else begin
                        c = cpl_q.pop_front();
                        chk("misaligned", 32'(misaligned), 32'(c.mis));
                        chk("bus_error", 32'(bus_error), 32'(c.err));
                        chk("load_data", load_data, c.ld);
                        last_ld = c.ld;
                    end
                end else if (in_ready) begin
                    chk("load_hold", load_data, last_ld);
                end
                prev = done;
            end
        end
    end

    task automatic txn(input rv32i_instr_e op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd,
                       input int rdy, input int rsp);
        req_t r;
        cpl_t c;
        int off;
        int lat;
        int n;
        bit mem;
        bit mis;
        bit seen;
        off = int'(a[1:0]);
        mem = m_load(op) || m_store(op);
        mis = m_misal(op, off);
        c.mis = mis;
        c.err = mem && !mis && rsp == 0;
        c.ld = (mem && !mis && rsp != 0) ? m_ld(op, off, rd) : 32'd0;
        lat = (!mem || mis) ? 1 : 2 + rdy + ((rsp == 0) ? TO : rsp);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = in_ready;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        if (mem && !mis) begin
            r.addr  = a & ~32'd3;
            r.we    = m_store(op);
            r.wstrb = m_strb(op, off);
            r.wdata = m_wdata(op, sd);
            r.rdy   = rdy;
            r.rsp   = rsp;
            r.rdata = rd;
            req_q.push_back(r);
        end
        cpl_q.push_back(c);
        in_valid = 1'b1;
        instr = op;
        addr = a;
        store_data = sd;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
                in_valid = 1'b0;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                instr = ops[$urandom_range(0, 9)];
                addr = $urandom;
                store_data = $urandom;
            end
        end
        in_valid = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) chk("latency", n, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        req_t r;
        rv32i_instr_e op;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'({misaligned, bus_error}), 32'd0);
        chk("rst_load_data", load_data, 32'd0);

        txn(SW,  32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1);
        txn(LB,  32'h203, 32'h0, 32'h80FF_1234, 0, 1);
        txn(LBU, 32'h203, 32'h0, 32'h80FF_1234, 0, 1);
        txn(LHU, 32'h202, 32'h0, 32'h80FF_1234, 1, 2);
        txn(SH,  32'h102, 32'h0000_ABCD, 32'h0, 0, 1);
        txn(SB,  32'h101, 32'h0000_005A, 32'h0, 0, 3);
        txn(LW,  32'h102, 32'h0, 32'h1234_5678, 0, 1);
        txn(ALU, 32'h100, 32'h0, 32'h0, 0, 1);
        txn(SW,  32'h104, 32'h1122_3344, 32'h0, 5, 2);
        txn(LW,  32'h108, 32'h0, 32'hCAFE_F00D, 0, 0);
        txn(LH,  32'h10A, 32'h0, 32'h8001_7FFF, 2, TO);

        // Reset while waiting for a response
        repeat (2) @(negedge clk);
        chk("pre_rst_idle", 32'(in_ready), 32'd1);
        r.addr = 32'h300; r.we = 1'b0; r.wstrb = 4'h0; r.wdata = '0;
        r.rdy = 0; r.rsp = 0; r.rdata = '0;
        req_q.push_back(r);
        in_valid = 1'b1;
        instr = LW;
        addr = 32'h300;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_req_valid", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray_cnt++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stray_done", 32'(done), 32'd0);
            chk("stray_in_ready", 32'(in_ready), 32'd1);
        end

        for (int t = 0; t < 150; t++) begin
            op = ops[$urandom_range(0, 9)];
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            txn(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, TO));
        end

        repeat (4) @(negedge clk);
        chk("queues_drained", 32'(req_q.size() + cpl_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
